// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall/flush handling, valid bit and occupancy FSM.
// Optional saturating bubble/stall counters are enabled with `define IDEX_PERF_CNT_EN.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     ctrl_d,
  input  logic            valid_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pcplus4_d,
  input  logic [XLEN-1:0] immext_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic [11:0]     ctrl_e,
  output logic [1:0]      resultsrc_e,
  output logic            memwrite_e,
  output logic            branch_e,
  output logic            alusrc_e,
  output logic            regwrite_e,
  output logic            jump_e,
  output logic [2:0]      alucontrol_e,
  output logic            valid_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pcplus4_e,
  output logic [XLEN-1:0] immext_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [1:0]      state_e
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned REG_W  = 5;
  // MemWrite, Branch, RegWrite and Jump: the bits that can change architectural state
  localparam logic [CTRL_W-1:0] GATE_MASK = 12'h0D8;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    FULL    = 2'b01,
    HELD    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pcplus4;
    logic [XLEN-1:0]   immext;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
  } payload_t;

  payload_t pay_d, pay_q;
  logic     valid_q;
  logic     load;
  state_t   state_q, state_nxt;

  assign load = !flush_e && !stall_e;

  // Gate state-changing controls at capture so ctrl_e comes straight from a flop
  always_comb begin
    pay_d         = '0;
    pay_d.ctrl    = valid_d ? ctrl_d : (ctrl_d & ~GATE_MASK);
    pay_d.rd1     = rd1_d;
    pay_d.rd2     = rd2_d;
    pay_d.pc      = pc_d;
    pay_d.pcplus4 = pcplus4_d;
    pay_d.immext  = immext_d;
    pay_d.rs1     = rs1_d;
    pay_d.rs2     = rs2_d;
    pay_d.rd      = rd_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_e) begin
      pay_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall_e) begin
      pay_q   <= pay_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY: begin
        if (load && valid_d) state_nxt = FULL;
      end
      FULL, HELD: begin
        if (flush_e)      state_nxt = EMPTY;
        else if (stall_e) state_nxt = HELD;
        else              state_nxt = valid_d ? FULL : EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign ctrl_e       = pay_q.ctrl;
  assign resultsrc_e  = pay_q.ctrl[11:10];
  assign memwrite_e   = pay_q.ctrl[7];
  assign branch_e     = pay_q.ctrl[6];
  assign alusrc_e     = pay_q.ctrl[5];
  assign regwrite_e   = pay_q.ctrl[4];
  assign jump_e       = pay_q.ctrl[3];
  assign alucontrol_e = pay_q.ctrl[2:0];
  assign valid_e      = valid_q;
  assign rd1_e        = pay_q.rd1;
  assign rd2_e        = pay_q.rd2;
  assign pc_e         = pay_q.pc;
  assign pcplus4_e    = pay_q.pcplus4;
  assign immext_e     = pay_q.immext;
  assign rs1_e        = pay_q.rs1;
  assign rs2_e        = pay_q.rs2;
  assign rd_e         = pay_q.rd;
  assign state_e      = state_q;

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] bubble_q, stall_q;
  logic             bubble_hit, stall_hit;

  assign bubble_hit = flush_e || (!stall_e && !valid_d);
  assign stall_hit  = !flush_e && stall_e;

  // Saturating counters: hold at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      if (bubble_hit && (bubble_q != '1)) bubble_q <= bubble_q + CNT_W'(1);
      if (stall_hit && (stall_q != '1))   stall_q  <= stall_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;
`endif

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Decode-to-execute pipeline register that captures the 12-bit control bundle from the decode-stage controller, plus the decode datapath fields, and presents them to the execute stage one cycle later. It sits directly downstream of the controller's bubble mux. It adds explicit stall (hold) and flush (bubble) handling, a valid bit, and a small occupancy state machine. Optional performance counters track bubbles and stall cycles.

## Interface
Parameters:
- XLEN, 32, datapath width of register, PC and immediate fields
- CNT_W, 16, width of each performance counter (used only with IDEX_PERF_CNT_EN)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ctrl_d  in  12  control bundle {ResultSrc[1:0], ImmSrc[1:0], MemWrite, Branch, ALUSrc, RegWrite, Jump, ALUControl[2:0]}, MSB first
- valid_d  in  1  decode stage holds a real instruction
- rd1_d, rd2_d  in  XLEN  register-file read data
- pc_d, pcplus4_d, immext_d  in  XLEN  PC, PC+4 and extended immediate
- rs1_d, rs2_d, rd_d  in  5  register addresses
- stall_e  in  1  hold current contents
- flush_e  in  1  load a bubble
- ctrl_e  out  12  registered bundle, same field order
- resultsrc_e  out  2  split field of ctrl_e[11:10]
- memwrite_e, branch_e, alusrc_e, regwrite_e, jump_e  out  1 each  split fields of ctrl_e[7:3]
- alucontrol_e  out  3  split field of ctrl_e[2:0]
- valid_e  out  1  execute stage holds a real instruction
- rd1_e, rd2_e, pc_e, pcplus4_e, immext_e  out  XLEN  registered datapath fields
- rs1_e, rs2_e, rd_e  out  5  registered addresses
- state_e  out  2  occupancy state encoding
- bubble_cnt, stall_cnt  out  CNT_W  perf counters (present only with macro)

## Operation
- Update priority per edge: flush_e > stall_e > load.
- Flush: every stored field becomes 0, and valid_e becomes 0.
- Stall without flush: all registers hold their values.
- Load: all fields capture the _d inputs, and valid_e becomes valid_d.
- Output gating: memwrite_e, regwrite_e, branch_e and jump_e are ANDed with valid_e. ctrl_e carries the gated values, so an invalid slot can never write state.
- State machine (state_e):
  - EMPTY=00: transitions to FULL on load with valid_d=1; stays EMPTY on load with valid_d=0, on flush, or on stall.
  - FULL=01: stall transitions to HELD; flush transitions to EMPTY; load transitions to FULL if valid_d=1, otherwise EMPTY.
  - HELD=10: stall stays HELD; flush transitions to EMPTY; load transitions to FULL or EMPTY as in FULL.
  - 11 is illegal and returns to EMPTY on the next edge.
- Stall and flush asserted together: flush wins and the state goes to EMPTY.

## Timing
- Latency: exactly 1 cycle from _d inputs to _e outputs.
- All outputs are registered. Split fields derive combinationally from the registered bundle and valid bit only.
- Reset: on rst_n low, asynchronously and regardless of clk, all outputs go to 0, state_e=EMPTY, and the counters go to 0. The first capture happens on the first rising edge after rst_n deasserts.
- Reset mid-stall: contents are lost. Upstream must re-issue.
- stall_e and flush_e are sampled at the rising edge. No combinational path exists from them to outputs.

## Configuration
- IDEX_PERF_CNT_EN defined:
  - bubble_cnt increments on every edge where flush_e=1, or where a load has valid_d=0.
  - stall_cnt increments on every edge where flush_e=0 and stall_e=1.
  - Both saturate at all-ones and never wrap.
- IDEX_PERF_CNT_EN undefined: the counters and their ports are removed, and all other behaviour is identical.

## Test plan
- Reset: rst_n low mid-cycle with FULL contents -> all outputs 0 and state_e=00 immediately, before the next edge.
- Load: ctrl_d=12'hA5B, valid_d=1, rd1_d=32'h1234 -> next cycle ctrl_e=12'hA5B with gating applied, rd1_e=32'h1234, valid_e=1, state_e=01.
- Stall: 3 cycles of stall_e=1 while inputs change -> outputs frozen, state_e=10, stall_cnt=3; first load afterwards -> state_e=01.
- Flush with stall: stall_e=1 and flush_e=1 in the same cycle -> ctrl_e=0, valid_e=0, state_e=00, bubble_cnt+1, stall_cnt unchanged.
- Invalid load: valid_d=0 with the RegWrite and MemWrite bits set in ctrl_d -> regwrite_e=0, memwrite_e=0, state_e=00.
- Saturation (CNT_W=4): 20 consecutive flushes -> bubble_cnt=4'hF, with no wrap.
